// File: rtl/arcade_input_pkg.sv
// -----------------------------------------------------------------------------
// arcade_input_pkg
// Shared constants and helpers for the arcade input mapper:
//   - joystick bit indices (hps_io per-player 16-bit word)
//   - joy_pcfrldu bit indices ({coin,start,fire,right,left,down,up})
//   - PS/2 scan-code constants, 9-bit {extended, code}
//   - keyboard key register indices
//   - rotate encoding, coin FSM states
//   - direction struct with SOCD-clean and rotate helpers
// -----------------------------------------------------------------------------
package arcade_input_pkg;

  // Joystick word bit positions.
  localparam int JOY_R      = 0;
  localparam int JOY_L      = 1;
  localparam int JOY_D      = 2;
  localparam int JOY_U      = 3;
  localparam int JOY_FIRE   = 4;
  localparam int JOY_START1 = 5;
  localparam int JOY_START2 = 6;
  localparam int JOY_COIN   = 7;

  // Per-player output bit positions.
  localparam int OUT_UP    = 0;
  localparam int OUT_DOWN  = 1;
  localparam int OUT_LEFT  = 2;
  localparam int OUT_RIGHT = 3;
  localparam int OUT_FIRE  = 4;
  localparam int OUT_START = 5;
  localparam int OUT_COIN  = 6;

  // PS/2 prefix bytes.
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Scan codes as {extended, code}. 9'h000 never matches a key.
  localparam logic [8:0] SC_P0_UP    = 9'h175;
  localparam logic [8:0] SC_P0_DOWN  = 9'h172;
  localparam logic [8:0] SC_P0_LEFT  = 9'h16B;
  localparam logic [8:0] SC_P0_RIGHT = 9'h174;
  localparam logic [8:0] SC_P0_SPACE = 9'h029;
  localparam logic [8:0] SC_P0_CTRL  = 9'h014;
  localparam logic [8:0] SC_P0_START = 9'h005;
  localparam logic [8:0] SC_P0_COIN  = 9'h02E;
  localparam logic [8:0] SC_P1_UP    = 9'h02D;
  localparam logic [8:0] SC_P1_DOWN  = 9'h02B;
  localparam logic [8:0] SC_P1_LEFT  = 9'h023;
  localparam logic [8:0] SC_P1_RIGHT = 9'h034;
  localparam logic [8:0] SC_P1_FIRE  = 9'h01C;
  localparam logic [8:0] SC_P1_START = 9'h006;
  localparam logic [8:0] SC_P1_COIN  = 9'h036;

  // Key register indices.
  localparam int KI_P0_UP    = 0;
  localparam int KI_P0_DOWN  = 1;
  localparam int KI_P0_LEFT  = 2;
  localparam int KI_P0_RIGHT = 3;
  localparam int KI_P0_SPACE = 4;
  localparam int KI_P0_CTRL  = 5;
  localparam int KI_P0_START = 6;
  localparam int KI_P0_COIN  = 7;
  localparam int KI_P1_UP    = 8;
  localparam int KI_P1_DOWN  = 9;
  localparam int KI_P1_LEFT  = 10;
  localparam int KI_P1_RIGHT = 11;
  localparam int KI_P1_FIRE  = 12;
  localparam int KI_P1_START = 13;
  localparam int KI_P1_COIN  = 14;
  localparam int NUM_KEYS    = 15;

  typedef enum logic [1:0] {
    ROT_0   = 2'd0,
    ROT_90  = 2'd1,
    ROT_180 = 2'd2,
    ROT_270 = 2'd3
  } rotate_e;

  typedef enum logic [1:0] {
    COIN_IDLE = 2'd0,
    COIN_HOLD_ST = 2'd1,
    COIN_GAP_ST  = 2'd2
  } coin_state_e;

  typedef struct packed {
    logic right;
    logic left;
    logic down;
    logic up;
  } dir_t;

  // Opposing directions pressed together cancel each other.
  function automatic dir_t socd_clean(input dir_t d);
    dir_t r;
    r = d;
    if (d.up && d.down) begin
      r.up   = 1'b0;
      r.down = 1'b0;
    end
    if (d.left && d.right) begin
      r.left  = 1'b0;
      r.right = 1'b0;
    end
    return r;
  endfunction

  // Screen rotation, expressed as "output direction <- input direction".
  function automatic dir_t rotate_dir(input dir_t d, input rotate_e rot);
    dir_t r;
    r = d;
    case (rot)
      ROT_90: begin
        r.up = d.left;  r.down = d.right; r.left = d.down;  r.right = d.up;
      end
      ROT_180: begin
        r.up = d.down;  r.down = d.up;    r.left = d.right; r.right = d.left;
      end
      ROT_270: begin
        r.up = d.right; r.down = d.left;  r.left = d.up;    r.right = d.down;
      end
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/arcade_input_mapper_if.sv
// -----------------------------------------------------------------------------
// arcade_input_mapper_if
// Bundle between hps_io side and the input mapper.
//   ps2_key     65 bits, bit 64 toggles once per key event
//   joystick    16 bits per player
//   rotate      0:none 1:90 2:180 3:270
//   joy_pcfrldu 7 bits per player {coin,start,fire,right,left,down,up}
//   kbd_active  any tracked key held
// master: the hps_io/stimulus side. slave: the mapper.
// -----------------------------------------------------------------------------
interface arcade_input_mapper_if #(
  parameter int NUM_PLAYERS = 2
);
  logic [64:0]                ps2_key;
  logic [16*NUM_PLAYERS-1:0]  joystick;
  logic [1:0]                 rotate;
  logic [7*NUM_PLAYERS-1:0]   joy_pcfrldu;
  logic                       kbd_active;

  modport master (
    output ps2_key, joystick, rotate,
    input  joy_pcfrldu, kbd_active
  );

  modport slave (
    input  ps2_key, joystick, rotate,
    output joy_pcfrldu, kbd_active
  );
endinterface

// File: rtl/arcade_coin_pulse.sv
// -----------------------------------------------------------------------------
// arcade_coin_pulse
// Turns a coin request level into a fixed-length coin pulse followed by a
// mandatory low gap. Only a rising edge seen in IDLE starts a pulse; edges
// during HOLD or GAP are dropped, and a request held through the gap does not
// retrigger.
//   clk_sys  in   system clock
//   reset_n  in   asynchronous active-low reset (coin drops immediately)
//   req      in   coin request level
//   coin     out  coin pulse, high for exactly COIN_HOLD cycles
// -----------------------------------------------------------------------------
module arcade_coin_pulse
  import arcade_input_pkg::*;
#(
  parameter int COIN_HOLD = 1200000,
  parameter int COIN_GAP  = 1200000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic req,
  output logic coin
);

  localparam int CNT_MAX = (COIN_HOLD > COIN_GAP) ? COIN_HOLD : COIN_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(COIN_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(COIN_GAP - 1);

  coin_state_e      state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             req_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= COIN_IDLE;
      cnt   <= '0;
      req_q <= 1'b0;
      coin  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      req_q <= req;
      coin  <= (state_d == COIN_HOLD_ST);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      COIN_IDLE: begin
        if (req && !req_q) begin
          state_d = COIN_HOLD_ST;
          cnt_d   = '0;
        end
      end
      COIN_HOLD_ST: begin
        if (cnt == HOLD_LAST) begin
          state_d = COIN_GAP_ST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      COIN_GAP_ST: begin
        if (cnt == GAP_LAST) begin
          state_d = COIN_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = COIN_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/arcade_input_mapper.sv
// -----------------------------------------------------------------------------
// arcade_input_mapper
// Decodes hps_io PS/2 key events into per-key hold registers and merges them
// with the hps_io joysticks into per-player control buses, with SOCD cleaning,
// screen rotation and a timed coin pulse per player.
//   clk_sys  in   system clock
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport: ps2_key, joystick, rotate in;
//            joy_pcfrldu, kbd_active out
// Timing: joystick/rotate -> joy_pcfrldu one edge; key event -> key reg at the
// edge it is seen, joy_pcfrldu one edge later; kbd_active follows key regs.
// -----------------------------------------------------------------------------
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int MERGE_JOY     = 0,
  parameter int COIN_ON_START = 0,
  parameter int COIN_HOLD     = 1200000,
  parameter int COIN_GAP      = 1200000,
  parameter int SOCD_CLEAN    = 1
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  arcade_input_mapper_if.slave   bus
);

  logic                old_state;
  logic                primed;
  logic                key_event;
  logic                pressed;
  logic                extended;
  logic [8:0]          code;
  logic [NUM_KEYS-1:0] key_q, key_d;
  logic [15:0]         joy_all;
  logic                unused_joy;

  // The first cycle after reset only captures the toggle bit, so whatever
  // value ps2_key[64] holds at reset is never mistaken for an event.
  assign key_event = primed && (old_state != bus.ps2_key[64]);

  // Not every joystick bit feeds every player; fold them here once.
  assign unused_joy = ^bus.joystick;

  always_comb begin
    pressed  = (bus.ps2_key[15:8] != PS2_BREAK);
    extended = pressed ? (bus.ps2_key[15:8] == PS2_EXT)
                       : (bus.ps2_key[23:16] == PS2_EXT);
    // Multi-byte sequences (PRNSCR/PAUSE) collapse to a code no key uses.
    code     = (|bus.ps2_key[63:24]) ? 9'h000 : {extended, bus.ps2_key[7:0]};

    key_d = key_q;
    if (key_event) begin
      case (code)
        SC_P0_UP:    key_d[KI_P0_UP]    = pressed;
        SC_P0_DOWN:  key_d[KI_P0_DOWN]  = pressed;
        SC_P0_LEFT:  key_d[KI_P0_LEFT]  = pressed;
        SC_P0_RIGHT: key_d[KI_P0_RIGHT] = pressed;
        SC_P0_SPACE: key_d[KI_P0_SPACE] = pressed;
        SC_P0_CTRL:  key_d[KI_P0_CTRL]  = pressed;
        SC_P0_START: key_d[KI_P0_START] = pressed;
        SC_P0_COIN:  key_d[KI_P0_COIN]  = pressed;
        SC_P1_UP:    if (NUM_PLAYERS > 1) key_d[KI_P1_UP]    = pressed;
        SC_P1_DOWN:  if (NUM_PLAYERS > 1) key_d[KI_P1_DOWN]  = pressed;
        SC_P1_LEFT:  if (NUM_PLAYERS > 1) key_d[KI_P1_LEFT]  = pressed;
        SC_P1_RIGHT: if (NUM_PLAYERS > 1) key_d[KI_P1_RIGHT] = pressed;
        SC_P1_FIRE:  if (NUM_PLAYERS > 1) key_d[KI_P1_FIRE]  = pressed;
        SC_P1_START: if (NUM_PLAYERS > 1) key_d[KI_P1_START] = pressed;
        SC_P1_COIN:  if (NUM_PLAYERS > 1) key_d[KI_P1_COIN]  = pressed;
        default: ;
      endcase
    end
  end

  // NOTE: only control registers exist here, and all of them are reset;
  // there is no storage array that could be left unreset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      old_state <= 1'b0;
      primed    <= 1'b0;
      key_q     <= '0;
    end else begin
      old_state <= bus.ps2_key[64];
      primed    <= 1'b1;
      key_q     <= key_d;
    end
  end

  assign bus.kbd_active = |key_q;

  always_comb begin
    joy_all = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      joy_all = joy_all | bus.joystick[16*p +: 16];
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [15:0] joy_p;
    dir_t        key_dir, raw_dir, clean_dir, rot_dir;
    logic        key_fire, key_start, key_coin;
    logic        fire, start, coin_req, coin;
    logic [5:0]  body_q;

    always_comb begin
      if (MERGE_JOY != 0) begin
        joy_p = (p == 0) ? joy_all : 16'h0000;
      end else begin
        joy_p = bus.joystick[16*p +: 16];
      end

      key_dir   = '0;
      key_fire  = 1'b0;
      key_start = 1'b0;
      key_coin  = 1'b0;
      if (p == 0) begin
        key_dir.up    = key_q[KI_P0_UP];
        key_dir.down  = key_q[KI_P0_DOWN];
        key_dir.left  = key_q[KI_P0_LEFT];
        key_dir.right = key_q[KI_P0_RIGHT];
        // Two fire keys: releasing one keeps fire while the other is held.
        key_fire      = key_q[KI_P0_SPACE] | key_q[KI_P0_CTRL];
        key_start     = key_q[KI_P0_START];
        key_coin      = key_q[KI_P0_COIN];
      end else if (p == 1) begin
        key_dir.up    = key_q[KI_P1_UP];
        key_dir.down  = key_q[KI_P1_DOWN];
        key_dir.left  = key_q[KI_P1_LEFT];
        key_dir.right = key_q[KI_P1_RIGHT];
        key_fire      = key_q[KI_P1_FIRE];
        key_start     = key_q[KI_P1_START];
        key_coin      = key_q[KI_P1_COIN];
      end

      raw_dir.up    = key_dir.up    | joy_p[JOY_U];
      raw_dir.down  = key_dir.down  | joy_p[JOY_D];
      raw_dir.left  = key_dir.left  | joy_p[JOY_L];
      raw_dir.right = key_dir.right | joy_p[JOY_R];
      fire          = key_fire | joy_p[JOY_FIRE];
      start         = key_start | ((p == 1) ? joy_p[JOY_START2] : joy_p[JOY_START1]);
      coin_req      = key_coin | joy_p[JOY_COIN] | ((COIN_ON_START != 0) & start);

      // Cleaning happens in cabinet orientation, before rotation.
      clean_dir = (SOCD_CLEAN != 0) ? socd_clean(raw_dir) : raw_dir;
      rot_dir   = rotate_dir(clean_dir, rotate_e'(bus.rotate));
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        body_q <= '0;
      end else begin
        body_q[OUT_UP]    <= rot_dir.up;
        body_q[OUT_DOWN]  <= rot_dir.down;
        body_q[OUT_LEFT]  <= rot_dir.left;
        body_q[OUT_RIGHT] <= rot_dir.right;
        body_q[OUT_FIRE]  <= fire;
        body_q[OUT_START] <= start;
      end
    end

    arcade_coin_pulse #(
      .COIN_HOLD (COIN_HOLD),
      .COIN_GAP  (COIN_GAP)
    ) u_coin (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .req     (coin_req),
      .coin    (coin)
    );

    // Coin bit comes straight from the pulse register, already aligned.
    assign bus.joy_pcfrldu[7*p +: 7] = {coin, body_q};
  end

endmodule
